// File: rtl/domain_handshake_sync_if.sv
// rtl/domain_handshake_sync_if.sv - source/destination signal bundle for domain_handshake_sync
interface domain_handshake_sync_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic [CNT_WIDTH-1:0]  o_xfer_count;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_data,
        input  o_valid,
        input  o_xfer_count
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_data,
        output o_valid,
        output o_xfer_count
    );
endinterface

// File: rtl/domain_handshake_sync.sv
// rtl/domain_handshake_sync.sv - toggle-handshake CDC bridge from i_clk_a to i_clk_b
module domain_handshake_sync #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    MODE        = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                    i_clk_a,
    input  logic                    rst,
    input  logic                    i_clk_b,
    domain_handshake_sync_if.slave  bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("domain_handshake_sync: SYNC_STAGES must be >= 2");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("domain_handshake_sync: MODE must be 0 or 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic [DATA_WIDTH-1:0]   data_hold_q, data_hold_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;
    logic                    launch;

    logic [SYNC_STAGES-1:0]  req_sync_q;
    logic                    req_s;
    logic                    ack_q;
    logic [DATA_WIDTH-1:0]   o_data_q;
    logic                    o_valid_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign req_s = req_sync_q[SYNC_STAGES-1];

    // Source domain: data_hold only changes on a launch, so it is frozen for all of WAIT.
    always_ff @(posedge i_clk_a or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            data_hold_q <= '0;
            ack_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            data_hold_q <= data_hold_d;
            ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        data_hold_d = data_hold_q;
        launch      = (MODE == 0) ? 1'b1 : bus.i_valid;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    data_hold_d = bus.i_data;
                    req_d       = ~req_q;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_s == req_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_ready = (state_q == S_IDLE) & rst;

    // Destination domain: data_hold is sampled only once the req toggle has been synchronised.
    always_ff @(posedge i_clk_b or negedge rst) begin
        if (!rst) begin
            req_sync_q <= '0;
            ack_q      <= 1'b0;
            o_data_q   <= RESET_VALUE;
            o_valid_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
            if (req_s != ack_q) begin
                o_data_q  <= data_hold_q;
                ack_q     <= ~ack_q;
                o_valid_q <= 1'b1;
                cnt_q     <= cnt_q + CNT_WIDTH'(1);
            end else begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_data       = o_data_q;
    assign bus.o_valid      = o_valid_q;
    assign bus.o_xfer_count = cnt_q;

endmodule

// File: tb/tb_domain_handshake_sync.sv
// tb/tb_domain_handshake_sync.sv - self-checking bench for domain_handshake_sync
`timescale 1ns/100ps
module tb_domain_handshake_sync;

    localparam int         SYNC_A = 3;
    localparam logic [7:0] RV_A   = 8'h5A;
    localparam logic [7:0] RV_B   = 8'h00;

    logic clk_a, clk_b, rst;
    int   ha = 5;
    int   hb = 20;

    int checks = 0;
    int errors = 0;

    domain_handshake_sync_if #(.DATA_WIDTH(8), .CNT_WIDTH(8))  bus_a ();
    domain_handshake_sync_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus_b ();

    domain_handshake_sync #(
        .DATA_WIDTH(8), .SYNC_STAGES(SYNC_A), .MODE(1), .RESET_VALUE(RV_A), .CNT_WIDTH(8)
    ) u_dut_ev (
        .i_clk_a(clk_a), .rst(rst), .i_clk_b(clk_b), .bus(bus_a)
    );

    domain_handshake_sync #(
        .DATA_WIDTH(8), .SYNC_STAGES(2), .MODE(0), .RESET_VALUE(RV_B), .CNT_WIDTH(16)
    ) u_dut_cst (
        .i_clk_a(clk_a), .rst(rst), .i_clk_b(clk_b), .bus(bus_b)
    );

    // b edges sit at x.3 ns so they never coincide with a edges.
    initial begin
        clk_a = 1'b0;
        forever #(ha) clk_a = ~clk_a;
    end
    initial begin
        clk_b = 1'b0;
        #0.3;
        forever #(hb) clk_b = ~clk_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: accepted words in order, with the b-cycle stamp of acceptance.
    logic [7:0] exp_q[$];
    int         t_q[$];
    int         b_cycles  = 0;
    int         model_cnt = 0;
    int         pulses_a  = 0;
    int         pulses_b  = 0;
    logic [7:0] prev_a    = RV_A;
    logic [7:0] prev_b    = RV_B;
    bit         chk_b     = 0;
    bit         tog_b     = 0;

    always @(posedge clk_b) b_cycles <= b_cycles + 1;

    initial begin
        bit         acc;
        logic [7:0] d;
        forever begin
            @(negedge clk_a);
            acc = rst && bus_a.o_ready && bus_a.i_valid;
            d   = bus_a.i_data;
            @(posedge clk_a);
            if (acc && rst) begin
                exp_q.push_back(d);
                t_q.push_back(b_cycles);
            end
        end
    end

    initial begin
        int         lat;
        logic [7:0] d;
        forever begin
            @(negedge clk_b);
            if (!rst) begin
                prev_a = RV_A;
            end else begin
                if (bus_a.o_valid) begin
                    pulses_a++;
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 32'd1, 32'd0);
                    end else begin
                        d   = exp_q.pop_front();
                        lat = b_cycles - t_q.pop_front();
                        model_cnt = (model_cnt + 1) % 256;
                        check("ev_data", bus_a.o_data, d);
                        check("ev_count", bus_a.o_xfer_count, model_cnt);
                        checks++;
                        if (lat < SYNC_A + 1 || lat > SYNC_A + 2) begin
                            errors++;
                            $display("FAIL latency actual=%0d required=%0d..%0d", lat, SYNC_A + 1, SYNC_A + 2);
                        end
                    end
                end else begin
                    check("ev_data_stable_without_valid", bus_a.o_data, prev_a);
                end
                prev_a = bus_a.o_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_b);
            if (!rst) begin
                prev_b = RV_B;
            end else begin
                if (chk_b) begin
                    check("cst_data_legal", (bus_b.o_data == 8'h00 || bus_b.o_data == 8'hFF), 32'd1);
                    if (bus_b.o_data != prev_b) check("cst_change_has_valid", bus_b.o_valid, 32'd1);
                    if (bus_b.o_valid) pulses_b++;
                end
                prev_b = bus_b.o_data;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_a);
            if (tog_b) begin
                #1;
                bus_b.i_data = ~bus_b.i_data;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk_a);
        #2;
        rst = 1'b0;
        exp_q.delete();
        t_q.delete();
        model_cnt = 0;
        repeat (5) @(posedge clk_a);
        repeat (5) @(posedge clk_b);
        #1;
        check("rst_a_data", bus_a.o_data, RV_A);
        check("rst_a_valid", bus_a.o_valid, 0);
        check("rst_a_ready", bus_a.o_ready, 0);
        check("rst_a_count", bus_a.o_xfer_count, 0);
        check("rst_b_data", bus_b.o_data, RV_B);
        check("rst_b_count", bus_b.o_xfer_count, 0);
        @(negedge clk_a);
        rst = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        int  n = 0;
        bit  r = 0;
        @(posedge clk_a);
        #1;
        bus_a.i_valid = 1'b1;
        bus_a.i_data  = d;
        while (!r && n < 500) begin
            @(negedge clk_a);
            r = bus_a.o_ready;
            @(posedge clk_a);
            #1;
            n++;
        end
        bus_a.i_valid = 1'b0;
        check("send_accepted", r, 1);
    endtask

    task automatic wait_pulses(input int target, input int budget, input bit ready_low);
        int n      = 0;
        bit rdy_hi = 0;
        while (pulses_a < target && n < budget) begin
            @(negedge clk_a);
            if (bus_a.o_ready) rdy_hi = 1;
            n++;
        end
        check("pulse_arrived", (pulses_a >= target), 1);
        if (ready_low) check("ready_low_in_wait", rdy_hi, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_a);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_data;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int p0;
        int acc;
        int n;
        bit r;

        vecs[0] = '{8'hA5, 8'hA5, 8'd1};
        vecs[1] = '{8'h00, 8'h00, 8'd2};
        vecs[2] = '{8'hFF, 8'hFF, 8'd3};
        vecs[3] = '{8'h3C, 8'h3C, 8'd4};
        vecs[4] = '{8'h81, 8'h81, 8'd5};

        rst           = 1'b0;
        bus_a.i_valid = 1'b0;
        bus_a.i_data  = 8'h00;
        bus_b.i_valid = 1'b0;
        bus_b.i_data  = 8'h00;

        // Reset values, then single transfers at a=100MHz / b=25MHz.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            p0 = pulses_a;
            send(vecs[i].data);
            wait_pulses(p0 + 1, 400, (i == 0));
            check("vec_data", bus_a.o_data, vecs[i].exp_data);
            check("vec_count", bus_a.o_xfer_count, vecs[i].exp_cnt);
        end

        // Reset while a word is in flight: it must vanish, and the next word counts from 1.
        send(8'h77);
        do_reset();
        p0 = pulses_a;
        repeat (20) @(posedge clk_b);
        #1;
        check("no_valid_after_mid_reset", pulses_a, p0);
        check("mid_reset_data", bus_a.o_data, RV_A);
        send(8'h3C);
        wait_pulses(p0 + 1, 400, 1'b0);
        check("post_reset_data", bus_a.o_data, 8'h3C);
        check("post_reset_count", bus_a.o_xfer_count, 1);

        // 256 back-to-back words with i_valid held; the 8-bit counter wraps to 0.
        ha = 5;
        hb = 5;
        do_reset();
        p0  = pulses_a;
        acc = 0;
        n   = 0;
        @(posedge clk_a);
        #1;
        bus_a.i_data  = 8'h00;
        bus_a.i_valid = 1'b1;
        while (acc < 256 && n < 20000) begin
            @(negedge clk_a);
            r = bus_a.o_ready;
            @(posedge clk_a);
            #1;
            n++;
            if (r) begin
                acc++;
                bus_a.i_data = 8'(acc);
                if (acc == 256) bus_a.i_valid = 1'b0;
            end
        end
        bus_a.i_valid = 1'b0;
        check("stream_accepted", acc, 256);
        drain(500);
        repeat (3) @(negedge clk_a);
        check("stream_pulses", pulses_a - p0, 256);
        check("stream_count_wrapped", bus_a.o_xfer_count, 0);

        // Random data and random i_valid at 7:3 and 3:7 clock ratios.
        for (int k = 0; k < 2; k++) begin
            ha = (k == 0) ? 7 : 3;
            hb = (k == 0) ? 3 : 7;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                @(posedge clk_a);
                #1;
                bus_a.i_valid = ($urandom_range(0, 3) != 0);
                bus_a.i_data  = 8'($urandom);
            end
            @(posedge clk_a);
            #1;
            bus_a.i_valid = 1'b0;
            drain(3000);
            repeat (3) @(negedge clk_a);
            check("random_final_count", bus_a.o_xfer_count, model_cnt);
        end

        // MODE0 with i_data toggling 00/FF every a-cycle, a=b/3 then a=3b.
        for (int k = 0; k < 2; k++) begin
            ha = (k == 0) ? 5 : 15;
            hb = (k == 0) ? 15 : 5;
            repeat (4) @(posedge clk_b);
            p0    = pulses_b;
            chk_b = 1;
            tog_b = 1;
            repeat (300) @(posedge clk_a);
            tog_b = 0;
            chk_b = 0;
            check("cst_pulses_seen", (pulses_b > p0), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
